// File: rtl/hskbus_uart_rx.sv
// 8N1 UART receiver for the merged housekeeping return line, with a single-entry
// stream output register and framing/overrun/good-byte status.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge on the synchronised line
// START      | half-bit wait, then confirm the start bit is still low
// DATA       | sample 8 data bits mid-bit, LSB first
// STOP       | sample the stop bit; high = good byte, low = framing error
// WAIT_HIGH  | bad stop seen; hold off until the line returns high
module hskbus_uart_rx #(
    parameter int CLKS_PER_BIT = 160
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic [7:0] rx_bytes_o,
    output logic       busy_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    logic          rx_meta_q, rx_s_q, rx_s_dly_q;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          deliver_q, deliver_d;
    logic          accept_q, accept_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    count_q, count_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        accept_d  = 1'b0;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        count_d   = count_q;

        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        // Accept/drop was decided in the stop-sample cycle; apply it now.
        if (deliver_q) begin
            if (accept_q) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
                count_d  = count_q + 8'd1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_s_dly_q && !rx_s_q) begin
                    timer_d = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    if (!rx_s_q) begin
                        timer_d  = FULL_LOAD;
                        bitcnt_d = 3'd0;
                        state_d  = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    timer_d  = FULL_LOAD;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    if (rx_s_q) begin
                        deliver_d = 1'b1;
                        accept_d  = !tvalid_q || m_tready;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'd0;
            deliver_q  <= 1'b0;
            accept_q   <= 1'b0;
            tdata_q    <= 8'd0;
            tvalid_q   <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s_q     <= rx_meta_q;
            rx_s_dly_q <= rx_s_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            deliver_q  <= deliver_d;
            accept_q   <= accept_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            count_q    <= count_d;
        end
    end

    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign framing_err_o = ferr_q;
    assign overrun_o     = ovr_q;
    assign rx_bytes_o    = count_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hskbus_uart_rx.sv
// Bench for hskbus_uart_rx: drives 8N1 frames (some at skewed baud) and checks
// delivered bytes, status pulses and counters against a queue/counter model.
module tb_hskbus_uart_rx;

    localparam int CPB = 24;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       framing_err;
    logic       overrun;
    logic [7:0] rx_bytes;
    logic       busy;

    hskbus_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (tready),
        .framing_err_o(framing_err),
        .overrun_o    (overrun),
        .rx_bytes_o   (rx_bytes),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int valid_cyc = 0;
    int model_cnt = 0;
    int ferr_save, ovr_save;
    logic tv_prev = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            cycles(cpb);
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int cpb);
        exp_q.push_back(b);
        model_cnt = (model_cnt + 1) % 256;
        send_frame(b, cpb, 1'b1);
    endtask

    // Scoreboard: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && tready) begin
                chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("byte_data", 32'(m_tdata), 32'(exp_q.pop_front()));
            end
            if (framing_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (m_tvalid) valid_cyc++;
            if (m_tvalid && !tv_prev) rise_cyc = cyc;
        end
        tv_prev = m_tvalid;
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        tready = 1'b1;
        cycles(4);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_bytes", 32'(rx_bytes), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cycles(3);

        // single 0x55, latency from line edge to m_tvalid
        send_good(8'h55, CPB);
        cycles(4);
        chk("latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        chk("bytes_after_55", 32'(rx_bytes), 32'(model_cnt));
        chk("tvalid_width", 32'(valid_cyc), 32'd1);

        // back-to-back, zero idle
        send_good(8'h00, CPB);
        send_good(8'hFF, CPB);
        send_good(8'hA5, CPB);
        cycles(4);
        chk("b2b_bytes", 32'(rx_bytes), 32'(model_cnt));
        chk("b2b_valid_cyc", 32'(valid_cyc), 32'd4);
        chk("b2b_ferr", 32'(ferr_cnt), 32'd0);
        chk("b2b_ovr", 32'(ovr_cnt), 32'd0);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // short low glitch is rejected
        rx = 1'b0;
        cycles(CPB / 4);
        chk("glitch_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        cycles(2 * CPB);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_valid", 32'(valid_cyc), 32'd4);
        chk("glitch_ferr", 32'(ferr_cnt), 32'd0);

        // bad stop then stuck-low line: exactly one framing error
        send_frame(8'h3C, CPB, 1'b0);
        cycles(2000);
        chk("break_busy", 32'(busy), 32'd1);
        chk("break_ferr", 32'(ferr_cnt), 32'd1);
        rx = 1'b1;
        cycles(5);
        chk("break_release", 32'(busy), 32'd0);
        chk("break_ferr_once", 32'(ferr_cnt), 32'd1);
        chk("break_no_byte", 32'(valid_cyc), 32'd4);
        chk("break_bytes", 32'(rx_bytes), 32'(model_cnt));

        // overrun: 0x22 dropped while 0x11 is held
        tready = 1'b0;
        send_good(8'h11, CPB);
        cycles(4);
        send_frame(8'h22, CPB, 1'b1);
        cycles(4);
        chk("ovr_hold_data", 32'(m_tdata), 32'h11);
        chk("ovr_hold_valid", 32'(m_tvalid), 32'd1);
        chk("ovr_pulse", 32'(ovr_cnt), 32'd1);
        chk("ovr_bytes", 32'(rx_bytes), 32'(model_cnt));
        tready = 1'b1;
        cycles(2);
        chk("ovr_drained", 32'(exp_q.size()), 32'd0);

        // tready raised exactly in the stop-sample cycle: no overrun
        tready = 1'b0;
        send_good(8'h11, CPB);
        cycles(4);
        fork
            send_good(8'h22, CPB);
            begin
                cycles(LAT - 2);
                tready = 1'b1;
            end
        join
        cycles(4);
        chk("late_ready_ovr", 32'(ovr_cnt), 32'd1);
        chk("late_ready_drained", 32'(exp_q.size()), 32'd0);
        chk("late_ready_bytes", 32'(rx_bytes), 32'(model_cnt));

        // reset mid-DATA with a byte pending
        tready = 1'b0;
        send_frame(8'h77, CPB, 1'b1);
        cycles(4);
        chk("pend_valid", 32'(m_tvalid), 32'd1);
        ferr_save = ferr_cnt;
        ovr_save = ovr_cnt;
        rx = 1'b0;
        cycles(3 + CPB / 2 + 3 * CPB);
        chk("mid_data_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        rx = 1'b1;
        cycles(2);
        rst = 1'b0;
        model_cnt = 0;
        cycles(1);
        chk("rst_mid_valid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_bytes", 32'(rx_bytes), 32'(model_cnt));
        tready = 1'b1;
        cycles(3 * CPB);
        chk("rst_mid_ferr", 32'(ferr_cnt), 32'(ferr_save));
        chk("rst_mid_ovr", 32'(ovr_cnt), 32'(ovr_save));

        // random bytes at skewed baud, back-to-back, through counter wrap
        for (int i = 0; i < 255; i++) begin
            send_good(8'($urandom_range(0, 255)), CPB - 1 + int'($urandom_range(0, 2)));
        end
        cycles(CPB);
        chk("count_255", 32'(rx_bytes), 32'(model_cnt));
        send_good(8'($urandom_range(0, 255)), CPB + 1);
        cycles(CPB);
        chk("count_wrap", 32'(rx_bytes), 32'(model_cnt));
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_ferr", 32'(ferr_cnt), 32'(ferr_save));
        chk("rand_ovr", 32'(ovr_cnt), 32'(ovr_save));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hskbus_uart_rx.md
Name: hskbus_uart_rx

Overview:
Byte-level UART receiver for the merged housekeeping return line, i.e. the combined SURF/hski2c RX after crate-enable gating. It sits directly downstream of the hskbus merge stage and runs on the 80 MHz init clock. It deframes 8N1 at 500 kbps and presents bytes on a single-entry AXI4-Stream-style output to the housekeeping packet parser. It also reports framing errors, overruns and a wrapping good-byte count for the ILA/status registers.

Parameters:
CLKS_PER_BIT, 160, clock cycles per UART bit (80 MHz / 500 kbps); must be even and >= 4.

Ports:
clk_i  in  1  system clock (80 MHz initclk)
rst_i  in  1  synchronous active-high reset
rx_i  in  1  merged hskbus RX line, asynchronous, idle high
m_tdata  out  8  received byte
m_tvalid  out  1  byte valid
m_tready  in  1  downstream accept
framing_err_o  out  1  one-cycle pulse on bad stop bit
overrun_o  out  1  one-cycle pulse when a good byte is dropped
rx_bytes_o  out  8  count of good bytes received, wraps 255->0
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high on rst_i; single clock clk_i.
- Reset values:
  - m_tdata=0, m_tvalid=0, framing_err_o=0, overrun_o=0, rx_bytes_o=0, busy_o=0.
  - Both synchroniser flops=1, FSM=IDLE, bit counter=0, timer=0.
- Input sync: 2-flop synchroniser on rx_i. rx_s is the second flop; rx_s_d is rx_s delayed one cycle. All FSM decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if rx_s_d=1 and rx_s=0, load timer=CLKS_PER_BIT/2-1 and go to START.
  - START: decrement timer. At timer==0, sample rx_s:
    - rx_s=0: timer=CLKS_PER_BIT-1, bitcnt=0, go to DATA.
    - rx_s=1: false start (glitch). Go to IDLE with no pulse.
  - DATA: decrement timer. At timer==0:
    - shift rx_s into the shift register, LSB first; timer=CLKS_PER_BIT-1; bitcnt++.
    - After the 8th sample (bitcnt was 7), go to STOP.
  - STOP: decrement timer. At timer==0, sample rx_s:
    - rx_s=1: good byte, go to IDLE.
    - rx_s=0: framing_err_o pulses 1 cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break or stuck-low line produces exactly one framing error.
- Good byte delivery, applied in the cycle after the stop sample:
  - If m_tvalid=0, or m_tvalid=1 and m_tready=1 in the stop-sample cycle: load m_tdata, set m_tvalid=1, rx_bytes_o++.
  - Otherwise: overrun_o pulses 1 cycle, the new byte is dropped, m_tdata/m_tvalid are unchanged, and rx_bytes_o is unchanged.
- Handshake:
  - m_tvalid clears on m_tvalid&m_tready unless a new byte loads in the same cycle, in which case it stays 1 with the new data.
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
- Timing: nominal sample point is mid-bit. Falling edge at rx_i to m_tvalid=1 is 2 (sync) + 1 (edge) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles = 1524 at the default.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge can be detected with zero idle time.
- Reset mid-frame: the FSM returns to IDLE immediately, any pending m_tvalid clears, and no pulses are generated.
- Line low coming out of reset: the synchroniser resets to 1, so a held-low line produces a falling edge, then a START, then a bad stop, giving one framing error and then WAIT_HIGH.

Test Plan:
- 0x55 8N1 at exactly 160 clk/bit, m_tready=1 -> m_tdata=0x55 with m_tvalid for 1 cycle, 1524 cycles after the start edge; rx_bytes_o=1.
- 0x00, 0xFF, 0xA5 back-to-back with no idle gap, m_tready=1 -> three bytes in order, rx_bytes_o=3, no error pulses.
- Low glitch of 40 cycles on an idle line -> returns to IDLE, m_tvalid stays 0, framing_err_o stays 0.
- 0x3C sent with stop bit forced low, then line held low for 2000 cycles -> exactly one framing_err_o pulse, no m_tvalid, busy_o high until the line returns high.
- m_tready=0, send 0x11 then 0x22 -> m_tdata stays 0x11, overrun_o pulses once, rx_bytes_o=1. Raising m_tready in the 0x22 stop-sample cycle instead -> 0x22 loads and no overrun.
- Baud error ±3% (155 and 165 clk/bit) with random bytes -> all bytes correct; assert rst_i mid-DATA -> m_tvalid=0, the next frame is received correctly, and rx_bytes_o wraps from 255 to 0 after 256 good bytes.
